// File: rtl/reg_bank_n_if.sv
// rtl/reg_bank_n_if.sv - operate/read bundle for the parametrised register bank
interface reg_bank_n_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             we;
    logic [2:0]       op;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             sin;
    logic             snap;
    logic             restore;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             cout;
    logic             err;

    modport master (
        output we, op, waddr, wdata, sin, snap, restore, raddr_a, raddr_b,
        input  rdata_a, rdata_b, cout, err
    );

    modport slave (
        input  we, op, waddr, wdata, sin, snap, restore, raddr_a, raddr_b,
        output rdata_a, rdata_b, cout, err
    );
endinterface

// File: rtl/reg_bank_n.sv
// rtl/reg_bank_n.sv - NUM_REGS x WIDTH register bank with operate port, two read ports and shadow bank
module reg_bank_n #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_REGS  = 4,
    parameter int               AW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    reg_bank_n_if.slave bus
);

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_CLR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_INC  = 3'd6,
        OP_DEC  = 3'd7
    } op_e;

    logic [WIDTH-1:0] live_q   [NUM_REGS];
    logic [WIDTH-1:0] live_d   [NUM_REGS];
    logic [WIDTH-1:0] shadow_q [NUM_REGS];
    logic [WIDTH-1:0] shadow_d [NUM_REGS];
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic             in_range;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic [WIDTH-1:0] rdata_a_w;
    logic [WIDTH-1:0] rdata_b_w;

    // Read muxes: addresses without a live register read as zero.
    always_comb begin
        rdata_a_w = '0;
        rdata_b_w = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.raddr_a == AW'(i)) rdata_a_w = live_q[i];
            if (bus.raddr_b == AW'(i)) rdata_b_w = live_q[i];
        end
    end

    assign bus.rdata_a = rdata_a_w;
    assign bus.rdata_b = rdata_b_w;
    assign bus.cout    = cout_q;
    assign bus.err     = err_q;

    // Target select: range check and current value of the addressed register.
    always_comb begin
        in_range = 1'b0;
        cur      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.waddr == AW'(i)) begin
                in_range = 1'b1;
                cur      = live_q[i];
            end
        end
    end

    // Operation datapath: new register value and carry/shift-out.
    always_comb begin
        res   = cur;
        res_c = 1'b0;
        case (op_e'(bus.op))
            OP_LOAD: begin res = bus.wdata;                     res_c = 1'b0;         end
            OP_CLR:  begin res = '0;                            res_c = 1'b0;         end
            OP_SHL:  begin res = {cur[WIDTH-2:0], bus.sin};     res_c = cur[WIDTH-1]; end
            OP_SHR:  begin res = {bus.sin, cur[WIDTH-1:1]};     res_c = cur[0];       end
            OP_ROL:  begin res = {cur[WIDTH-2:0], cur[WIDTH-1]}; res_c = cur[WIDTH-1]; end
            OP_ROR:  begin res = {cur[0], cur[WIDTH-1:1]};      res_c = cur[0];       end
            OP_INC:  begin res = cur + WIDTH'(1);               res_c = &cur;         end
            OP_DEC:  begin res = cur - WIDTH'(1);               res_c = ~|cur;        end
            default: begin res = cur;                           res_c = 1'b0;         end
        endcase
    end

    // Next state: restore wins over any op; snap always captures pre-edge live values.
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        cout_d   = cout_q;
        err_d    = bus.we & ~in_range;
        if (bus.snap) begin
            shadow_d = live_q;
        end
        if (bus.restore) begin
            live_d = shadow_q;
        end else if (bus.we && in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.waddr == AW'(i)) live_d[i] = res;
            end
            cout_d = res_c;
        end
    end

    // State registers with immediate reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= '{default: RESET_VAL};
            shadow_q <= '{default: '0};
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_n.sv
// tb/tb_reg_bank_n.sv - self-checking bench for reg_bank_n (WIDTH=8, NUM_REGS=3)
module tb_reg_bank_n;

    logic clk;
    logic rst;
    bit   started;
    int   checks;
    int   errors;

    reg_bank_n_if #(.WIDTH(8), .AW(2)) bus ();

    reg_bank_n #(
        .WIDTH(8), .NUM_REGS(3), .AW(2), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer registers updated by the operation rules.
    int mlive   [4];
    int mshadow [4];
    int mtmp    [4];
    int ma;
    int mr;
    bit mcout;
    bit merr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mlive[i]   = 0;
                mshadow[i] = 0;
            end
            mcout = 1'b0;
            merr  = 1'b0;
        end else begin
            ma   = int'(bus.waddr);
            merr = bus.we && (ma >= 3);
            if (bus.restore) begin
                mtmp  = mlive;
                mlive = mshadow;
                if (bus.snap) mshadow = mtmp;
            end else begin
                if (bus.snap) mshadow = mlive;
                if (bus.we && ma < 3) begin
                    mr = mlive[ma];
                    case (int'(bus.op))
                        0: begin mlive[ma] = int'(bus.wdata); mcout = 0; end
                        1: begin mlive[ma] = 0; mcout = 0; end
                        2: begin mlive[ma] = (mr * 2 + int'(bus.sin)) % 256; mcout = (mr >= 128); end
                        3: begin mlive[ma] = mr / 2 + 128 * int'(bus.sin); mcout = (mr % 2 == 1); end
                        4: begin mlive[ma] = (mr * 2) % 256 + mr / 128; mcout = (mr >= 128); end
                        5: begin mlive[ma] = mr / 2 + 128 * (mr % 2); mcout = (mr % 2 == 1); end
                        6: begin mlive[ma] = (mr + 1) % 256; mcout = (mr == 255); end
                        default: begin mlive[ma] = (mr + 255) % 256; mcout = (mr == 0); end
                    endcase
                end
            end
        end
    end

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
        int ai;
        ai = int'(a);
        return (ai < 3) ? 8'(mlive[ai]) : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("model rdata_a", bus.rdata_a, exp_rd(bus.raddr_a));
            chk("model rdata_b", bus.rdata_b, exp_rd(bus.raddr_b));
            chk("model cout", {7'b0, bus.cout}, {7'b0, mcout});
            chk("model err", {7'b0, bus.err}, {7'b0, merr});
        end
    end

    task automatic idle();
        bus.we      = 1'b0;
        bus.op      = 3'd0;
        bus.waddr   = 2'd0;
        bus.wdata   = 8'h00;
        bus.sin     = 1'b0;
        bus.snap    = 1'b0;
        bus.restore = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [1:0] b);
        bus.raddr_a = a;
        bus.raddr_b = b;
    endtask

    // One clock with the given operate-port inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic w, input logic [2:0] o, input logic [1:0] a,
                       input logic [7:0] d, input logic s, input logic sn, input logic rs);
        bus.we      = w;
        bus.op      = o;
        bus.waddr   = a;
        bus.wdata   = d;
        bus.sin     = s;
        bus.snap    = sn;
        bus.restore = rs;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        rst     = 1'b1;
        idle();
        rd(2'd0, 2'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        started = 1'b1;
        #1;
        chk("reset rdata_a", bus.rdata_a, 8'h00);
        chk("reset cout", {7'b0, bus.cout}, 8'h00);
        chk("reset err", {7'b0, bus.err}, 8'h00);

        // Async reset in the middle of a cycle.
        cyc(1, 3'd0, 2'd0, 8'hBC, 0, 0, 0);
        cyc(1, 3'd2, 2'd0, 8'h00, 0, 0, 0);
        chk("pre-reset r0", bus.rdata_a, 8'h78);
        chk("pre-reset cout", {7'b0, bus.cout}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset r0", bus.rdata_a, 8'h00);
        chk("async reset cout", {7'b0, bus.cout}, 8'h00);
        chk("async reset err", {7'b0, bus.err}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Shift and rotate on r1.
        rd(2'd1, 2'd2);
        cyc(1, 3'd0, 2'd1, 8'hBC, 0, 0, 0);
        cyc(1, 3'd2, 2'd1, 8'h00, 1, 0, 0);
        chk("shl r1", bus.rdata_a, 8'h79);
        chk("shl cout", {7'b0, bus.cout}, 8'h01);
        cyc(1, 3'd5, 2'd1, 8'h00, 0, 0, 0);
        chk("ror r1", bus.rdata_a, 8'hBC);
        chk("ror cout", {7'b0, bus.cout}, 8'h01);
        cyc(1, 3'd3, 2'd1, 8'h00, 0, 0, 0);
        chk("shr r1", bus.rdata_a, 8'h5E);
        chk("shr cout", {7'b0, bus.cout}, 8'h00);

        // Increment/decrement wrap on r2.
        cyc(1, 3'd0, 2'd2, 8'hFF, 0, 0, 0);
        cyc(1, 3'd6, 2'd2, 8'h00, 0, 0, 0);
        chk("inc wrap r2", bus.rdata_b, 8'h00);
        chk("inc wrap cout", {7'b0, bus.cout}, 8'h01);
        cyc(1, 3'd7, 2'd2, 8'h00, 0, 0, 0);
        chk("dec borrow r2", bus.rdata_b, 8'hFF);
        chk("dec borrow cout", {7'b0, bus.cout}, 8'h01);
        cyc(1, 3'd7, 2'd2, 8'h00, 0, 0, 0);
        chk("dec r2", bus.rdata_b, 8'hFE);
        chk("dec cout", {7'b0, bus.cout}, 8'h00);
        cyc(1, 3'd4, 2'd2, 8'h00, 0, 0, 0);
        chk("rol r2", bus.rdata_b, 8'hFD);
        chk("rol cout", {7'b0, bus.cout}, 8'h01);

        // Same-cycle read returns the old value.
        bus.we = 1'b1; bus.op = 3'd1; bus.waddr = 2'd1;
        #1;
        chk("no bypass r1", bus.rdata_a, 8'h5E);
        @(posedge clk);
        #1;
        idle();
        chk("clr r1", bus.rdata_a, 8'h00);
        chk("clr cout", {7'b0, bus.cout}, 8'h00);
        cyc(1, 3'd4, 2'd2, 8'h00, 0, 0, 0);
        chk("rol2 r2", bus.rdata_b, 8'hFB);

        // Out-of-range target.
        rd(2'd2, 2'd3);
        cyc(1, 3'd0, 2'd3, 8'h55, 0, 0, 0);
        chk("oor err", {7'b0, bus.err}, 8'h01);
        chk("oor cout hold", {7'b0, bus.cout}, 8'h01);
        chk("oor r2", bus.rdata_a, 8'hFB);
        chk("oor read", bus.rdata_b, 8'h00);
        cyc(0, 3'd0, 2'd0, 8'h00, 0, 0, 0);
        chk("oor err drop", {7'b0, bus.err}, 8'h00);

        // Snapshot then restore; restore discards a same-cycle op.
        rd(2'd0, 2'd2);
        cyc(1, 3'd0, 2'd0, 8'h11, 0, 0, 0);
        cyc(0, 3'd0, 2'd0, 8'h00, 0, 1, 0);
        cyc(1, 3'd0, 2'd0, 8'h22, 0, 1, 0);
        chk("snap live r0", bus.rdata_a, 8'h22);
        cyc(1, 3'd2, 2'd2, 8'h00, 0, 0, 1);
        chk("restore r0", bus.rdata_a, 8'h11);
        chk("restore r2", bus.rdata_b, 8'hFB);
        chk("restore cout hold", {7'b0, bus.cout}, 8'h00);
        cyc(1, 3'd0, 2'd3, 8'h00, 0, 0, 1);
        chk("restore oor err", {7'b0, bus.err}, 8'h01);

        // Swap with a discarded load.
        cyc(1, 3'd0, 2'd0, 8'hAA, 0, 0, 0);
        cyc(0, 3'd0, 2'd0, 8'h00, 0, 1, 0);
        cyc(1, 3'd0, 2'd0, 8'h33, 0, 0, 0);
        cyc(1, 3'd0, 2'd0, 8'h77, 0, 1, 1);
        chk("swap live r0", bus.rdata_a, 8'hAA);
        cyc(0, 3'd0, 2'd0, 8'h00, 0, 0, 1);
        chk("swap shadow r0", bus.rdata_a, 8'h33);

        repeat (3) cyc(0, 3'd0, 2'd0, 8'h00, 0, 0, 0);
        chk("idle hold r0", bus.rdata_a, 8'h33);

        @(negedge clk);
        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_n.md
Name: reg_bank_n

Overview:
- Parametrised successor to the fixed two-channel 8-bit register set: NUM_REGS registers of WIDTH bits each.
- One synchronous write/operate port supports load, clear, shift, rotate and increment/decrement operations.
- Two independent combinational read ports.
- A shadow bank supports snapshot/restore/swap of the whole register set.
- Used as a general scratch/state register block in datapath designs and driven by the team's small controllers.

Parameters:
- WIDTH, 8, bits per register (>=2)
- NUM_REGS, 4, number of registers (>=2, need not be a power of 2)
- AW, 2, address width; must satisfy 2**AW >= NUM_REGS
- RESET_VAL, 0, reset value of every live register (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- we  input  1  perform op on register waddr this cycle
- op  input  3  operation select (encoding below)
- waddr  input  AW  target register of op
- wdata  input  WIDTH  load data (op=LOAD)
- sin  input  1  serial-in bit for SHL/SHR
- snap  input  1  copy all live registers to shadow
- restore  input  1  copy all shadow registers to live
- raddr_a  input  AW  read port A address
- raddr_b  input  AW  read port B address
- rdata_a  output  WIDTH  live[raddr_a], combinational
- rdata_b  output  WIDTH  live[raddr_b], combinational
- cout  output  1  registered carry/shift-out of last executed op
- err  output  1  registered 1-cycle pulse on out-of-range waddr with we=1

Behaviour:
- Reset (async, immediate, also mid-operation):
  - every live register = RESET_VAL; every shadow register = 0
  - cout = 0, err = 0
  - reads reflect RESET_VAL combinationally while rst is high
- Op encoding, applied at the clk edge when we=1 and waddr < NUM_REGS; R = live[waddr]:
  - 0 LOAD: R=wdata; cout=0
  - 1 CLR: R=0; cout=0
  - 2 SHL: R={R[WIDTH-2:0],sin}; cout=R[WIDTH-1]
  - 3 SHR: R={sin,R[WIDTH-1:1]}; cout=R[0]
  - 4 ROL: R={R[WIDTH-2:0],R[WIDTH-1]}; cout=R[WIDTH-1]
  - 5 ROR: R={R[0],R[WIDTH-1:1]}; cout=R[0]
  - 6 INC: R=R+1 mod 2**WIDTH; cout=1 only when R was all-ones (wrap)
  - 7 DEC: R=R-1 mod 2**WIDTH; cout=1 only when R was 0 (borrow)
- Latency: result is visible on read ports the cycle after the edge. No write-to-read bypass; a same-cycle read of waddr returns the old value.
- cout updates only on an executed op and holds otherwise.
- Out of range (waddr >= NUM_REGS, we=1): no register changes, cout holds, err=1 for exactly one cycle. err=0 on any cycle without that condition. Reads of an out-of-range address return 0.
- Snapshot/restore, all registers in one cycle:
  - snap only: shadow[i] = live[i] (pre-edge values, so a same-cycle op result is NOT captured)
  - restore only: live[i] = shadow[i]; restore overrides any same-cycle op; cout holds; err still flags an out-of-range waddr
  - snap & restore together: swap, i.e. shadow gets old live and live gets old shadow; a same-cycle op is discarded
- Inputs idle (we=0, snap=0, restore=0): all state holds.

Test Plan (WIDTH=8, NUM_REGS=3, AW=2, RESET_VAL=8'h00):
- Assert rst mid-cycle after LOAD r0=8'hBC -> rdata_a(r0)=8'h00 immediately; cout=0; err=0.
- LOAD r1=8'hBC, then SHL sin=1 -> r1=8'h79, cout=1; then ROR -> r1=8'hBC, cout=1; then SHR sin=0 -> r1=8'h5E, cout=0.
- LOAD r2=8'hFF, then INC -> r2=8'h00, cout=1; then DEC -> r2=8'hFF, cout=1; then DEC -> r2=8'hFE, cout=0.
- we=1, waddr=3, LOAD 8'h55 -> err high exactly 1 cycle; r0..r2 unchanged; rdata_b with raddr_b=3 reads 8'h00.
- r0=8'h11, snap; then LOAD r0=8'h22 with snap=1 in the same cycle -> shadow r0=8'h11 (pre-edge), live r0=8'h22; restore -> live r0=8'h11.
- Shadow r0=8'hAA and live r0=8'h33; snap+restore together with we=1 LOAD r0=8'h77 -> live r0=8'hAA, shadow r0=8'h33, LOAD discarded.
